dpcm_decoder: RTL

- Reconstructs samples from a DPCM residual stream, the inverse of the team's DPCM encoder (difference + saturation).
- Each accepted residual is clamped to the residual range, added to the previous reconstructed sample, and the sum is clamped to the sample range.
- Sits on the consumer side of a DDLS-style Valid/Ready/DataIn/DataOut link; ports are flat signals.

---
 rtl/dpcm_pkg.sv | 37 +++
 rtl/dpcm_clamp.sv | 26 ++
 rtl/dpcm_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/dpcm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dpcm_pkg                                                      |
// | Brief    : Shared DPCM types, default widths and signed saturation.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package dpcm_pkg;

    localparam int DEFAULT_SAMPLE_W = 16;
    localparam int DEFAULT_RES_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        CLAMP = 2'd2
    } DecState;

    // Symmetric mode drops the most negative code so the range is +/-(2^(w-1)-1).
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int                 width,
        input bit                 symmetric = 1'b0
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = symmetric ? -hi : -hi - 64'sd1;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpcm_clamp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dpcm_clamp                                                    |
// | Brief    : Combinational signed clamp of an IN_W value to OUT_W range,   |
// |            result sign-extended to OUT_EXT_W bits.                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dpcm_clamp
    import dpcm_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int OUT_EXT_W = 32,
    parameter bit SYMMETRIC = 1'b0
) (
    input  logic signed [IN_W-1:0]      value,
    output logic signed [OUT_EXT_W-1:0] clamped
);

    logic signed [63:0] w_sat;

    assign w_sat   = sat_signed(64'(value), OUT_W, SYMMETRIC);
    assign clamped = OUT_EXT_W'(w_sat);

endmodule
`default_nettype wire

// File: rtl/dpcm_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dpcm_decoder                                                  |
// | Brief    : DPCM reconstruction: residual clamp, accumulate, sample clamp.|
// |            Optional Sat output with DPCM_DEC_SAT_FLAG_EN.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dpcm_decoder
    import dpcm_pkg::*;
#(
    parameter int DW       = 32,
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int RES_W    = DEFAULT_RES_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Valid,
    input  logic [DW-1:0] DataIn,
    output logic          Ready,
    output logic [DW-1:0] DataOut
`ifdef DPCM_DEC_SAT_FLAG_EN
    ,
    output logic          Sat
`endif
);

    DecState r_state;
    DecState w_next_state;

    logic signed [DW-1:0] r_res;
    logic signed [DW:0]   r_sum;
    logic signed [DW-1:0] r_pred;
    logic signed [DW-1:0] w_res_clamped;
    logic signed [DW-1:0] w_sum_clamped;

    dpcm_clamp #(
        .IN_W      (DW),
        .OUT_W     (RES_W),
        .OUT_EXT_W (DW),
        .SYMMETRIC (1'b1)
    ) u_res_clamp (
        .value   (DataIn),
        .clamped (w_res_clamped)
    );

    dpcm_clamp #(
        .IN_W      (DW + 1),
        .OUT_W     (SAMPLE_W),
        .OUT_EXT_W (DW),
        .SYMMETRIC (1'b0)
    ) u_sum_clamp (
        .value   (r_sum),
        .clamped (w_sum_clamped)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (Valid) w_next_state = ADD;
            ADD:     w_next_state = CLAMP;
            CLAMP:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Sum is one bit wider than the operands so it cannot wrap before clamping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res  <= '0;
            r_sum  <= '0;
            r_pred <= '0;
        end else begin
            case (r_state)
                IDLE:    if (Valid) r_res <= w_res_clamped;
                ADD:     r_sum <= {r_pred[DW-1], r_pred} + {r_res[DW-1], r_res};
                CLAMP:   r_pred <= w_sum_clamped;
                default: ;
            endcase
        end
    end

    assign Ready   = (r_state == IDLE);
    assign DataOut = r_pred;

`ifdef DPCM_DEC_SAT_FLAG_EN
    logic r_res_clip;
    logic r_sat;
    logic w_res_clip;
    logic w_sum_clip;

    assign w_res_clip = (w_res_clamped != DataIn);
    assign w_sum_clip = ({w_sum_clamped[DW-1], w_sum_clamped} != r_sum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_clip <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            if (r_state == IDLE && Valid)
                r_res_clip <= w_res_clip;
            if (r_state == CLAMP)
                r_sat <= r_res_clip | w_sum_clip;
        end
    end

    assign Sat = r_sat;
`endif

endmodule
`default_nettype wire
